// File: rtl/clock_div_prog_pkg.sv
// Shared definitions for the programmable multi-channel clock divider.
package clock_div_pkg;

    // Smallest divisor that produces a running output; anything below stops the channel.
    localparam int unsigned DIV_MIN = 2;

    // Channel operating state, derived from the active divisor.
    typedef enum logic [0:0] {
        CH_STOP = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/clock_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
interface clock_div_prog_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH > 1 ? NUM_CH : 2);

    logic [NUM_CH-1:0] en;
    logic              sync_clr;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [WIDTH-1:0]  wr_div;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;

    modport master (
        output en, sync_clr, wr_en, wr_ch, wr_div,
        input  clk_out, tick, pend
    );

    modport slave (
        input  en, sync_clr, wr_en, wr_ch, wr_div,
        output clk_out, tick, pend
    );
endinterface

// File: rtl/clock_div_prog_chan.sv
// One divider channel: period counter, active and pending divisor, registered outputs.
module clock_div_chan
    import clock_div_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int unsigned RESET_DIV = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             sync_clr_i,
    input  logic             wr_hit_i,
    input  logic [WIDTH-1:0] wr_div_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             pend_o
);
    typedef logic [WIDTH-1:0] div_t;

    localparam div_t RESET_DIV_W = div_t'(RESET_DIV);
    localparam div_t DIV_MIN_W   = div_t'(DIV_MIN);
    localparam div_t ONE_W       = div_t'(1);

    // Number of high cycles in a full period: ceil(d/2).
    function automatic div_t hi_len(input div_t d);
        return d - (d >> 1);
    endfunction

    div_t      cnt_q, cnt_d;
    div_t      div_q, div_d;
    div_t      pend_div_q, pend_div_d;
    logic      pend_q, pend_d;
    logic      clk_out_q, clk_out_d;
    logic      tick_q, tick_d;
    ch_state_e state_s;

    // Channel runs only while the active divisor is at least DIV_MIN.
    always_comb begin
        if (div_q >= DIV_MIN_W) begin
            state_s = CH_RUN;
        end else begin
            state_s = CH_STOP;
        end
    end

    // Next-state: phase-align, stop hold, counting and boundary-time divisor apply, write capture.
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;

        if (sync_clr_i) begin
            // Restart the period; divisor and any pending write survive.
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else begin
            case (state_s)
                CH_STOP: begin
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    if (pend_q) begin
                        div_d  = pend_div_q;
                        pend_d = 1'b0;
                    end else begin
                        div_d  = div_q;
                    end
                end
                CH_RUN: begin
                    if (!en_i) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q == div_q - ONE_W) begin
                        // Period boundary: new divisor (if pending) takes effect from cnt=0.
                        cnt_d = '0;
                        if (pend_q) begin
                            div_d  = pend_div_q;
                            pend_d = 1'b0;
                        end else begin
                            div_d  = div_q;
                        end
                        if (div_d >= DIV_MIN_W) begin
                            tick_d    = 1'b1;
                            clk_out_d = (cnt_d < hi_len(div_d));
                        end else begin
                            // Dropping into STOP: outputs go low at once, no runt pulse.
                            tick_d    = 1'b0;
                            clk_out_d = 1'b0;
                        end
                    end else begin
                        cnt_d     = cnt_q + ONE_W;
                        clk_out_d = (cnt_d < hi_len(div_q));
                    end
                end
                default: begin
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                end
            endcase
        end

        // A write always lands in the pending slot; last write wins.
        if (wr_hit_i) begin
            pend_div_d = wr_div_i;
            pend_d     = 1'b1;
        end else begin
            pend_div_d = pend_div_d;
        end
    end

    // State registers with asynchronous reset to the power-on divisor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            div_q      <= RESET_DIV_W;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/clock_div_prog.sv
// Multi-channel programmable clock divider: write decode plus one channel per output.
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          NUM_CH    = 4,
    parameter int unsigned RESET_DIV = 100
) (
    input  logic             clk,
    input  logic             reset,
    clock_div_prog_if.slave  bus
);
    logic [NUM_CH-1:0] wr_hit_s;
    logic [NUM_CH-1:0] clk_out_s;
    logic [NUM_CH-1:0] tick_s;
    logic [NUM_CH-1:0] pend_s;

    // Decode the write strobe to a one-hot channel hit; out-of-range channels match nothing.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.wr_en && (int'(bus.wr_ch) == i)) begin
                wr_hit_s[i] = 1'b1;
            end else begin
                wr_hit_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clock_div_chan #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .en_i       (bus.en[g]),
            .sync_clr_i (bus.sync_clr),
            .wr_hit_i   (wr_hit_s[g]),
            .wr_div_i   (bus.wr_div),
            .clk_out_o  (clk_out_s[g]),
            .tick_o     (tick_s[g]),
            .pend_o     (pend_s[g])
        );
    end

    assign bus.clk_out = clk_out_s;
    assign bus.tick    = tick_s;
    assign bus.pend    = pend_s;

endmodule
